// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_fifo peripheral.
// Holds the TX/RX state encodings, the divisor floor and the widest frame payload.
package uart_pkg;

  localparam int MIN_DIV       = 4;
  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Clamp a raw divisor so every bit lasts at least MIN_DIV clocks
  function automatic logic [31:0] sat_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO for received characters.
// Pointers carry one extra wrap bit; full/empty come from comparing that bit.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then
  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  // Head of queue is visible combinationally; reads as zero while empty
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; reset discards all stored entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, written without reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: UART with runtime baud divisor, FWFT receive FIFO, sticky errors
// and a valid/ready transmit holding register.
// Define UART_PARITY_EN to build parity framing; otherwise frames never carry parity.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   clk_freq,
  input  logic                          stop2,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          rx,
  input  logic                          rx_read,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  input  logic                          err_clear,
  output logic                          err_frame,
  output logic                          err_parity,
  output logic                          err_overrun,
  input  logic                          irq_en,
  output logic                          irq
);

  localparam logic [31:0] BAUD_DIV  = 32'(BAUD_RATE);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);

  logic [31:0] clk_div_q;

  tx_state_e   tx_state_q, tx_state_d;
  logic [31:0] tx_cnt_q, tx_cnt_d, tx_div_q;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_data_q;
  logic        tx_stop2_q, tx_q, tx_d, tx_tick, tx_start;
  logic        tx_par_on, tx_par_bit;

  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] rx_cnt_q, rx_cnt_d, rx_div_q;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q;
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall, rx_start;
  logic        rx_tick, rx_half, rx_push_q, rx_push_d, rx_frame_bad_q, rx_par_on;

  logic        err_frame_q, err_overrun_q, fifo_full, fifo_empty, overrun_set;

  // Divisor tracks clk_freq every cycle; each frame captures its own copy at start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_div_q <= '0;
    else     clk_div_q <= sat_div(clk_freq / BAUD_DIV);
  end

  assign tx_start = (tx_state_q == TX_IDLE) && tx_valid;
  assign tx_tick  = (tx_cnt_q == tx_div_q - 32'd1);

  // TX state register; tx itself is registered so reset forces the line high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: each state holds for one divisor period per bit
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 32'd1;
    tx_bit_d   = tx_bit_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (tx_valid) tx_state_d = TX_START;
      end
      TX_START: if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_q == LAST_BIT) begin
            tx_bit_d   = '0;
            tx_state_d = tx_par_on ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
      TX_STOP: begin
        if (tx_tick) begin
          if (!tx_stop2_q || tx_bit_q == 3'd1) tx_state_d = TX_IDLE;
          else                                 tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: line level follows the state being entered, so tx falls right after accept
  always_comb begin
    tx_ready = (tx_state_q == TX_IDLE);
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_data_q[tx_bit_d];
      TX_PARITY: tx_d = tx_par_bit;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  assign rx_fall  = rx_s3_q & ~rx_s2_q;
  assign rx_start = (rx_state_q == RX_IDLE) && rx_fall;
  assign rx_tick  = (rx_cnt_q == rx_div_q - 32'd1);
  assign rx_half  = (rx_cnt_q == (rx_div_q >> 1) - 32'd1);

  // RX synchroniser and state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_push_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_push_q  <= rx_push_d;
    end
  end

  // RX next state: mid-start check rejects glitches, then one sample per bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 32'd1;
    rx_bit_d   = rx_bit_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_half) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_d = '0;
          if (rx_bit_q == LAST_BIT) begin
            rx_bit_d   = '0;
            rx_state_d = rx_par_on ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs: the stop sample always pushes, good stop bit or not
  always_comb begin
    rx_push_d = (rx_state_q == RX_STOP) && rx_tick;
  end

  // Frame datapath registers: per-frame divisor/config snapshots and shift data
  always_ff @(posedge clk) begin
    if (tx_start) begin
      tx_div_q   <= sat_div(clk_div_q);
      tx_data_q  <= tx_data & DATA_MASK;
      tx_stop2_q <= stop2;
    end
    if (rx_start) begin
      rx_div_q   <= sat_div(clk_div_q);
      rx_shift_q <= '0;
    end else if (rx_state_q == RX_DATA && rx_tick) begin
      rx_shift_q[rx_bit_q] <= rx_s2_q;
    end
    if (rx_push_d) rx_frame_bad_q <= ~rx_s2_q;
  end

`ifdef UART_PARITY_EN
  logic tx_par_en_q, tx_par_odd_q, rx_par_en_q, rx_par_odd_q, rx_par_bit_q;
  logic rx_par_bad, err_parity_q;

  // Parity mode is captured per frame so mid-frame register writes cannot split it
  always_ff @(posedge clk) begin
    if (tx_start) begin
      tx_par_en_q  <= parity_en;
      tx_par_odd_q <= parity_odd;
    end
    if (rx_start) begin
      rx_par_en_q  <= parity_en;
      rx_par_odd_q <= parity_odd;
    end
    if (rx_state_q == RX_PARITY && rx_tick) rx_par_bit_q <= rx_s2_q;
  end

  assign tx_par_on  = tx_par_en_q;
  assign tx_par_bit = (^tx_data_q) ^ tx_par_odd_q;
  assign rx_par_on  = rx_par_en_q;
  assign rx_par_bad = rx_par_en_q & (rx_par_bit_q != ((^rx_shift_q) ^ rx_par_odd_q));

  // Sticky parity error; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            err_parity_q <= 1'b0;
    else if (rx_push_q && rx_par_bad)   err_parity_q <= 1'b1;
    else if (err_clear)                 err_parity_q <= 1'b0;
  end

  assign err_parity = err_parity_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
  assign tx_par_on  = 1'b0;
  assign tx_par_bit = 1'b1;
  assign rx_par_on  = 1'b0;
  assign err_parity = 1'b0;
`endif

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push_q),
    .wdata_i (rx_shift_q),
    .pop_i   (rx_read),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (rx_level)
  );

  assign rx_valid    = ~fifo_empty;
  assign overrun_set = rx_push_q & fifo_full & ~(rx_read & ~fifo_empty);

  // Sticky frame and overrun errors; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      if (rx_push_q && rx_frame_bad_q) err_frame_q <= 1'b1;
      else if (err_clear)              err_frame_q <= 1'b0;
      if (overrun_set)                 err_overrun_q <= 1'b1;
      else if (err_clear)              err_overrun_q <= 1'b0;
    end
  end

  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
  assign irq         = irq_en & (rx_valid | err_frame | err_parity | err_overrun);

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: scoreboard bench for uart_fifo at divisor 10 (1.152 MHz / 115200).
// Stimulus pushes expected bytes into queues; RX and TX monitors pop and compare.
`timescale 1ns/1ps
module tb_uart_fifo;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] clk_freq;
  logic        stop2, parity_en, parity_odd, rx, rx_read;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [4:0]  rx_level;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, tx, err_clear, err_frame, err_parity, err_overrun, irq_en, irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  rx_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  bit          tx_mon_en = 1'b1;
  logic [7:0]  tx_got;

  always #5 clk = ~clk;

  uart_fifo #(
    .BAUD_RATE  (115200),
    .DATA_BITS  (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_freq    (clk_freq),
    .stop2       (stop2),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .rx          (rx),
    .rx_read     (rx_read),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_level    (rx_level),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx          (tx),
    .err_clear   (err_clear),
    .err_frame   (err_frame),
    .err_parity  (err_parity),
    .err_overrun (err_overrun),
    .irq_en      (irq_en),
    .irq         (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One serial frame at 10 clocks per bit, LSB first
  task automatic send_rx(input logic [7:0] b, input bit use_par, input bit par_bit,
                         input bit stop_bit);
    rx = 1'b0;
    step(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(10);
    end
    if (use_par) begin
      rx = par_bit;
      step(10);
    end
    rx = stop_bit;
    step(10);
    rx = 1'b1;
    step(2);
  endtask

  task automatic pop_one();
    rx_read = 1'b1;
    step(1);
    rx_read = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b, output int low_cycles, output int frame_cycles);
    int cnt;
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    check("tx_ready_busy", tx_ready, 1'b0);
    cnt = 0;
    while (tx === 1'b0 && cnt < 50) begin
      step(1);
      cnt++;
    end
    low_cycles = cnt;
    while (tx_ready !== 1'b1 && cnt < 500) begin
      step(1);
      cnt++;
    end
    frame_cycles = cnt;
  endtask

  // RX monitor: every accepted pop is compared with the scoreboard head
  always @(negedge clk) begin
    if (rx_read && rx_valid) begin
      if (rx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected_pop: got 0x%0h, required no entry", rx_data);
      end else begin
        check("rx_data_sb", rx_data, rx_exp_q.pop_front());
      end
    end
  end

  // TX monitor: decode each frame at mid-bit and compare with the scoreboard head
  initial begin
    forever begin
      @(negedge tx);
      if (tx_mon_en) begin
        step(5);
        check("tx_start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          step(10);
          tx_got[i] = tx;
        end
        step(10);
        check("tx_stop_bit", tx, 1'b1);
        if (tx_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected_frame: got 0x%0h, required no frame", tx_got);
        end else begin
          check("tx_byte_sb", tx_got, tx_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_c, frame_c;
    rst = 1'b1; clk_freq = 32'd1_152_000; stop2 = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
    rx = 1'b1; rx_read = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; err_clear = 1'b0; irq_en = 1'b1;
    step(3);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_level", rx_level, 5'd0);
    check("rst_errs", {err_frame, err_parity, err_overrun}, 3'b000);
    check("rst_irq", irq, 1'b0);
    check("rst_clk_div", dut.clk_div_q, 32'd0);
    rst = 1'b0;
    step(3);
    check("clk_div", dut.clk_div_q, 32'd10);

    // 8N1 transmit of 0xA5
    tx_exp_q.push_back(8'hA5);
    send_tx(8'hA5, low_c, frame_c);
    check("tx_low_cycles", low_c, 10);
    check("tx_frame_cycles", frame_c, 100);

    // Two stop bits lengthen the frame by one bit period
    stop2 = 1'b1;
    tx_exp_q.push_back(8'h3C);
    send_tx(8'h3C, low_c, frame_c);
    check("tx_stop2_frame_cycles", frame_c, 110);
    stop2 = 1'b0;
    step(5);

    // Receive 0x3C and pop it
    rx_exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b0, 1'b0, 1'b1);
    check("rx_valid_after_frame", rx_valid, 1'b1);
    check("rx_level_one", rx_level, 5'd1);
    check("rx_head_3c", rx_data, 8'h3C);
    check("irq_rx_valid", irq, 1'b1);
    irq_en = 1'b0;
    #1;
    check("irq_masked", irq, 1'b0);
    irq_en = 1'b1;
    pop_one();
    check("rx_valid_after_pop", rx_valid, 1'b0);
    check("irq_after_pop", irq, 1'b0);

    // Three-cycle glitch is a false start
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(30);
    check("glitch_no_push", rx_level, 5'd0);
    check("glitch_rx_idle", 32'(dut.rx_state_q), 32'(RX_IDLE));
    rx_exp_q.push_back(8'h81);
    send_rx(8'h81, 1'b0, 1'b0, 1'b1);
    pop_one();

    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_exp_q.push_back(8'(8'h10 + i));
      send_rx(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      if (i == 15) begin
        check("fifo_full_level", rx_level, 5'd16);
        check("no_overrun_at_full", err_overrun, 1'b0);
      end
    end
    check("overrun_level", rx_level, 5'd16);
    check("overrun_flag", err_overrun, 1'b1);
    check("overrun_head", rx_data, 8'h10);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check("overrun_cleared", err_overrun, 1'b0);
    rx_read = 1'b1;
    step(16);
    rx_read = 1'b0;
    check("drained_valid", rx_valid, 1'b0);
    check("drained_level", rx_level, 5'd0);
    pop_one();
    check("pop_empty_level", rx_level, 5'd0);

    // Low stop bit: byte still pushed, frame error sticky until cleared
    rx_exp_q.push_back(8'h55);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    check("frame_err_set", err_frame, 1'b1);
    check("frame_err_pushed", rx_level, 5'd1);
    pop_one();
    check("frame_err_sticky", err_frame, 1'b1);
    check("irq_from_error", irq, 1'b1);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check("frame_err_cleared", err_frame, 1'b0);
    check("irq_after_clear", irq, 1'b0);

`ifdef UART_PARITY_EN
    // Even parity: 0x01 needs parity 1, send 0 to force an error
    parity_en = 1'b1;
    parity_odd = 1'b0;
    rx_exp_q.push_back(8'h01);
    send_rx(8'h01, 1'b1, 1'b0, 1'b1);
    check("parity_err_set", err_parity, 1'b1);
    check("parity_err_pushed", rx_level, 5'd1);
    pop_one();
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    rx_exp_q.push_back(8'h03);
    send_rx(8'h03, 1'b1, 1'b0, 1'b1);
    check("parity_ok_no_err", err_parity, 1'b0);
    pop_one();
    tx_exp_q.push_back(8'h01);
    send_tx(8'h01, low_c, frame_c);
    check("tx_parity_frame_cycles", frame_c, 110);
    parity_en = 1'b0;
`else
    // Parity controls have no effect in this build
    parity_en = 1'b1;
    rx_exp_q.push_back(8'h01);
    send_rx(8'h01, 1'b0, 1'b0, 1'b1);
    check("parity_ignored", err_parity, 1'b0);
    pop_one();
    tx_exp_q.push_back(8'h01);
    send_tx(8'h01, low_c, frame_c);
    check("tx_no_parity_frame_cycles", frame_c, 100);
    parity_en = 1'b0;
`endif

    // Reset during a transmit, with a byte waiting in the FIFO
    send_rx(8'h77, 1'b0, 1'b0, 1'b1);
    check("pre_reset_level", rx_level, 5'd1);
    tx_mon_en = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(35);
    check("mid_tx_low", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("reset_tx_high", tx, 1'b1);
    check("reset_tx_ready", tx_ready, 1'b1);
    check("reset_fifo_empty", rx_valid, 1'b0);
    check("reset_level", rx_level, 5'd0);
    step(2);
    rst = 1'b0;
    step(2);

    check("rx_scoreboard_empty", rx_exp_q.size(), 0);
    check("tx_scoreboard_empty", tx_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
